bcd_serial_add_ctrl: RTL and testbench

Sequencer that performs a multi-digit packed-BCD addition by time-sharing a single one-digit BCD add/correct stage, one digit per clock, least-significant digit first. It accepts operands over a valid/ready handshake, carries between digits internally, and presents the result over a second valid/ready handshake. It is the control wrapper that lets the team's one-digit BCD adder datapath serve arbitrary operand widths at a cost of one cycle per digit.

---
 rtl/bcd_serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that time-shares one digit add/correct stage,
// one digit per clock, LSD first, with valid/ready handshakes on both sides.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic [4*DIGITS-1:0]   a_q, a_d;
    logic [4*DIGITS-1:0]   b_q, b_d;
    logic [4*DIGITS-1:0]   sum_q, sum_d;
    logic                  cout_q, cout_d;
    logic                  invalid_q, invalid_d;

    logic [3:0]            a_dig;
    logic [3:0]            b_dig;
    logic [4:0]            raw;
    logic [4:0]            corr;
    logic                  over9;

    // Single shared digit stage; the correction is applied even to non-BCD digits.
    always_comb begin
        a_dig = a_q[4*idx_q +: 4];
        b_dig = b_q[4*idx_q +: 4];
        raw   = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        corr  = raw + 5'd6;
        over9 = (raw > 5'd9);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    sum_d     = '0;
                    cout_d    = 1'b0;
                    invalid_d = 1'b0;
                    idx_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                sum_d[4*idx_q +: 4] = over9 ? corr[3:0] : raw[3:0];
                carry_d             = over9;
                if ((a_dig > 4'd9) || (b_dig > 4'd9)) begin
                    invalid_d = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    cout_d  = over9;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (done_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q == StRun);
    assign done_valid  = (state_q == StDone);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign invalid     = invalid_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl: reset, sums, carry chain,
// backpressure, invalid digits and reset during RUN.
module tb_bcd_serial_add_ctrl;

    localparam int unsigned DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_valid;
    logic                start_ready;
    logic [4*DIGITS-1:0] a;
    logic [4*DIGITS-1:0] b;
    logic                cin;
    logic                busy;
    logic                done_valid;
    logic                done_ready;
    logic [4*DIGITS-1:0] sum;
    logic                cout;
    logic                invalid;

    int checks = 0;
    int errors = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and pass its accept edge.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        check("start_ready_before_accept", 32'(start_ready), 32'd1);
        a           = av;
        b           = bv;
        cin         = cv;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    // Called just after the accept edge; follows RUN cycle by cycle into DONE.
    task automatic expect_result(input string tag, input logic [15:0] es,
                                 input logic ec, input logic ei);
        check({tag, "_busy_0"}, 32'(busy), 32'd1);
        check({tag, "_dv_0"}, 32'(done_valid), 32'd0);
        for (int k = 1; k < DIGITS; k++) begin
            step();
            check({tag, "_busy_run"}, 32'(busy), 32'd1);
            check({tag, "_dv_run"}, 32'(done_valid), 32'd0);
        end
        step();
        check({tag, "_dv_done"}, 32'(done_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_invalid"}, 32'(invalid), 32'(ei));
    endtask

    task automatic retire(input string tag, input logic [15:0] es);
        done_ready = 1'b1;
        step();
        check({tag, "_ret_ready"}, 32'(start_ready), 32'd1);
        check({tag, "_ret_dv"}, 32'(done_valid), 32'd0);
        check({tag, "_ret_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        rst         = 1'b1;
        start_valid = 1'(($urandom) & 1);
        a           = 16'($urandom);
        b           = 16'($urandom);
        cin         = 1'(($urandom) & 1);
        done_ready  = 1'(($urandom) & 1);
        step();
        step();
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        rst         = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b1;
        step();

        launch(16'h1234, 16'h5678, 1'b0);
        expect_result("basic", 16'h6912, 1'b0, 1'b0);
        retire("basic", 16'h6912);

        launch(16'h9999, 16'h0001, 1'b0);
        expect_result("chain1", 16'h0000, 1'b1, 1'b0);
        retire("chain1", 16'h0000);

        launch(16'h9999, 16'h9999, 1'b1);
        expect_result("chain2", 16'h9999, 1'b1, 1'b0);
        retire("chain2", 16'h9999);

        // Backpressure: new requests in DONE must be ignored.
        done_ready = 1'b0;
        launch(16'h0456, 16'h0544, 1'b0);
        expect_result("bp", 16'h1000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            a           = 16'h1111 * 16'(k + 1);
            b           = 16'h2222;
            start_valid = ~start_valid;
            step();
            check("bp_hold_dv", 32'(done_valid), 32'd1);
            check("bp_hold_sum", 32'(sum), 32'h1000);
            check("bp_hold_cout", 32'(cout), 32'd0);
            check("bp_no_accept", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        retire("bp", 16'h1000);
        launch(16'h5000, 16'h5000, 1'b0);
        expect_result("bp_next", 16'h0000, 1'b1, 1'b0);
        retire("bp_next", 16'h0000);

        launch(16'h00A0, 16'h0000, 1'b0);
        expect_result("inv", 16'h0100, 1'b0, 1'b1);
        retire("inv", 16'h0100);
        check("inv_sticky_idle", 32'(invalid), 32'd1);

        // Reset on the second RUN edge discards the operation.
        launch(16'h1234, 16'h5678, 1'b0);
        step();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_start_ready", 32'(start_ready), 32'd1);
        check("mid_busy_clr", 32'(busy), 32'd0);
        check("mid_dv", 32'(done_valid), 32'd0);
        check("mid_sum", 32'(sum), 32'd0);
        check("mid_cout", 32'(cout), 32'd0);
        check("mid_invalid", 32'(invalid), 32'd0);
        for (int k = 0; k < DIGITS + 2; k++) begin
            step();
            check("mid_no_done", 32'(done_valid), 32'd0);
        end
        launch(16'h0005, 16'h0005, 1'b0);
        expect_result("after_rst", 16'h0010, 1'b0, 1'b0);
        retire("after_rst", 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
